// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/ALU-op constants and control bundle types (PCU_EXTENDED_OPS_EN selects extra opcodes)
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

`ifdef PCU_EXTENDED_OPS_EN
   localparam bit EXT_OPS = 1'b1;
`else
   localparam bit EXT_OPS = 1'b0;
`endif

   // Full decode bundle, held in ID/EX.
   typedef struct packed {
      logic       regDst;
      logic       aluSrc;
      logic [1:0] aluOp;
      logic       branch;
      logic       branchNe;
      logic       jump;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       regWrite;
   } ctrl_t;

   // Bits still needed once the instruction has left EX.
   typedef struct packed {
      logic branch;
      logic branchNe;
      logic jump;
      logic memRead;
      logic memWrite;
      logic memToReg;
      logic regWrite;
   } mem_ctrl_t;

   // Bits still needed in WB.
   typedef struct packed {
      logic memToReg;
      logic regWrite;
   } wb_ctrl_t;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - ID-side inputs and per-stage control outputs of the control unit
interface pipelined_control_unit_if #(
   parameter int OPCODE_W = 6,
   parameter int REG_W    = 5,
   parameter int ALUOP_W  = 2
);
   logic [OPCODE_W-1:0] opCode;
   logic                idValid;
   logic [REG_W-1:0]    idRs;
   logic [REG_W-1:0]    idRt;
   logic                flush;
   logic                stall;
   logic                exRegDst;
   logic                exAluSrc;
   logic [ALUOP_W-1:0]  exAluOp;
   logic                memBranch;
   logic                memBranchNe;
   logic                memJump;
   logic                memMemRead;
   logic                memMemWrite;
   logic                wbMemToReg;
   logic                wbRegWrite;
   logic                illegalOp;

   modport master (
      output opCode, idValid, idRs, idRt, flush,
      input  stall, exRegDst, exAluSrc, exAluOp,
             memBranch, memBranchNe, memJump, memMemRead, memMemWrite,
             wbMemToReg, wbRegWrite, illegalOp
   );

   modport slave (
      input  opCode, idValid, idRs, idRt, flush,
      output stall, exRegDst, exAluSrc, exAluOp,
             memBranch, memBranchNe, memJump, memMemRead, memMemWrite,
             wbMemToReg, wbRegWrite, illegalOp
   );
endinterface

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode decoder (PCU_EXTENDED_OPS_EN adds addi/bne/j)
import ctrl_pkg::*;

module ctrl_decoder #(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] opcode,
   output ctrl_t               ctrl,
   output logic                legal
);

   // Unlisted fields, don't-cares included, stay 0 so bubbles and decodes share one encoding.
   always_comb begin
      ctrl  = '0;
      legal = 1'b1;
      case (opcode)
         OPCODE_W'(OP_RTYPE): begin
            ctrl.regDst   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_FUNCT;
         end
         OPCODE_W'(OP_LW): begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memRead  = 1'b1;
            ctrl.memToReg = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OPCODE_W'(OP_SW): begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memWrite = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OPCODE_W'(OP_BEQ): begin
            ctrl.branch = 1'b1;
            ctrl.aluOp  = ALUOP_SUB;
         end
`ifdef PCU_EXTENDED_OPS_EN
         OPCODE_W'(OP_ADDI): begin
            ctrl.aluSrc   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OPCODE_W'(OP_BNE): begin
            ctrl.branchNe = 1'b1;
            ctrl.aluOp    = ALUOP_SUB;
         end
         OPCODE_W'(OP_J): begin
            ctrl.jump = 1'b1;
         end
`endif
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - pipelined main control with load-use stall and bubble insertion (PCU_EXTENDED_OPS_EN)
import ctrl_pkg::*;

module pipelined_control_unit #(
   parameter int OPCODE_W = 6,
   parameter int REG_W    = 5,
   parameter int ALUOP_W  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   pipelined_control_unit_if.slave   bus
);

   ctrl_t            id_ctrl;
   logic             id_legal;
   ctrl_t            id_ex;
   logic [REG_W-1:0] ex_rt;
   mem_ctrl_t        ex_mem;
   wb_ctrl_t         mem_wb;
   logic             illegal_q;
   logic             load_use;
   logic             bubble;

   ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
      .opcode (bus.opCode),
      .ctrl   (id_ctrl),
      .legal  (id_legal)
   );

   // rt is compared even when the ID instruction has no rt source; the odd false stall is cheaper than decoding it.
   assign load_use  = bus.idValid & id_ex.memRead & ((ex_rt == bus.idRs) | (ex_rt == bus.idRt));
   assign bus.stall = load_use & ~bus.flush;
   assign bubble    = bus.stall | bus.flush | ~bus.idValid | ~id_legal;

   // ID/EX: decoded bundle, or an all-zero bubble when the ID instruction must not advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         id_ex <= '0;
         ex_rt <= '0;
      end else if (bubble) begin
         id_ex <= '0;
         ex_rt <= '0;
      end else begin
         id_ex <= id_ctrl;
         ex_rt <= bus.idRt;
      end
   end

   // EX/MEM: a taken branch/jump kills the instruction leaving EX.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         ex_mem <= '0;
      end else begin
         ex_mem.branch   <= id_ex.branch;
         ex_mem.branchNe <= id_ex.branchNe;
         ex_mem.jump     <= id_ex.jump;
         ex_mem.memRead  <= id_ex.memRead;
         ex_mem.memWrite <= id_ex.memWrite;
         ex_mem.memToReg <= id_ex.memToReg;
         ex_mem.regWrite <= id_ex.regWrite;
      end
   end

   // MEM/WB: the instruction in MEM always completes, including the one that flushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_wb <= '0;
      end else begin
         mem_wb.memToReg <= ex_mem.memToReg;
         mem_wb.regWrite <= ex_mem.regWrite;
      end
   end

   // One-cycle flag for a real, unflushed instruction with an unsupported opcode.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= bus.idValid & ~id_legal & ~bus.flush;
      end
   end

   assign bus.exRegDst    = id_ex.regDst;
   assign bus.exAluSrc    = id_ex.aluSrc;
   assign bus.exAluOp     = ALUOP_W'(id_ex.aluOp);
   assign bus.memBranch   = ex_mem.branch;
   assign bus.memBranchNe = ex_mem.branchNe & EXT_OPS;
   assign bus.memJump     = ex_mem.jump & EXT_OPS;
   assign bus.memMemRead  = ex_mem.memRead;
   assign bus.memMemWrite = ex_mem.memWrite;
   assign bus.wbMemToReg  = mem_wb.memToReg;
   assign bus.wbRegWrite  = mem_wb.regWrite;
   assign bus.illegalOp   = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for pipelined_control_unit (honours PCU_EXTENDED_OPS_EN)
module tb_pipelined_control_unit;

   localparam int R   = 0;
   localparam int LW  = 35;
   localparam int SW  = 43;
   localparam int BEQ = 4;

   typedef struct {
      int         id;
      logic       st;
      logic [3:0] ex;   // {regDst, aluSrc, aluOp}
      logic [4:0] mem;  // {branch, branchNe, jump, memRead, memWrite}
      logic [1:0] wb;   // {memToReg, regWrite}
      logic       ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   step_no = 0;
   exp_t sb[$];

   pipelined_control_unit_if #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(2)) bus ();

   pipelined_control_unit #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Apply one cycle of ID inputs and queue the expected stall and post-edge stage outputs.
   task automatic step(input logic rst, input int op, input logic v, input int rs, input int rt,
                       input logic fl, input logic st, input logic [3:0] ex, input logic [4:0] mem,
                       input logic [1:0] wb, input logic ill);
      exp_t e;
      @(negedge clk);
      reset       = rst;
      bus.opCode  = 6'(op);
      bus.idValid = v;
      bus.idRs    = 5'(rs);
      bus.idRt    = 5'(rt);
      bus.flush   = fl;
      step_no++;
      e.id  = step_no;
      e.st  = st;
      e.ex  = ex;
      e.mem = mem;
      e.wb  = wb;
      e.ill = ill;
      sb.push_back(e);
   endtask

   // Monitor: stall is checked mid-cycle, registered outputs just after the following edge.
   initial begin
      exp_t        e;
      logic [11:0] act, req;
      forever begin
         @(negedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb[0];
            tests++;
            if (bus.stall !== e.st) begin
               fails++;
               $display("FAIL step %0d stall: got %b expected %b", e.id, bus.stall, e.st);
            end
            @(posedge clk);
            #1;
            act = {bus.exRegDst, bus.exAluSrc, bus.exAluOp,
                   bus.memBranch, bus.memBranchNe, bus.memJump, bus.memMemRead, bus.memMemWrite,
                   bus.wbMemToReg, bus.wbRegWrite, bus.illegalOp};
            req = {e.ex, e.mem, e.wb, e.ill};
            tests++;
            if (act !== req) begin
               fails++;
               $display("FAIL step %0d stages {ex,mem,wb,ill}: got %b expected %b", e.id, act, req);
            end
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      bus.opCode  = '0;
      bus.idValid = 1'b0;
      bus.idRs    = '0;
      bus.idRt    = '0;
      bus.flush   = 1'b0;

      //   rst op   v  rs rt fl   st    ex       mem        wb     ill
      // reset
      step(1, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(1, R,   1, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      // R-type through the pipe
      step(0, R,   1, 1, 2, 0,  0, 4'b1010, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b01, 0);
      // lw rt=5 then add rs=5: one stall cycle
      step(0, LW,  1, 1, 5, 0,  0, 4'b0100, 5'b00000, 2'b00, 0);
      step(0, R,   1, 5, 6, 0,  1, 4'b0000, 5'b00010, 2'b00, 0);
      step(0, R,   1, 5, 6, 0,  0, 4'b1010, 5'b00000, 2'b11, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b01, 0);
      // beq in MEM flushes, lw in EX and sw in ID die
      step(0, BEQ, 1, 1, 2, 0,  0, 4'b0001, 5'b00000, 2'b00, 0);
      step(0, LW,  1, 1, 7, 0,  0, 4'b0100, 5'b10000, 2'b00, 0);
      step(0, SW,  1, 2, 3, 1,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      // hazard and flush together: flush wins
      step(0, LW,  1, 1, 4, 0,  0, 4'b0100, 5'b00000, 2'b00, 0);
      step(0, SW,  1, 4, 9, 1,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      // hazard through rt
      step(0, LW,  1, 1, 8, 0,  0, 4'b0100, 5'b00000, 2'b00, 0);
      step(0, SW,  1, 3, 8, 0,  1, 4'b0000, 5'b00010, 2'b00, 0);
      step(0, SW,  1, 3, 8, 0,  0, 4'b0100, 5'b00000, 2'b11, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00001, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      // matching register but no valid ID instruction: no stall
      step(0, LW,  1, 1, 10, 0, 0, 4'b0100, 5'b00000, 2'b00, 0);
      step(0, R,   0, 10, 10, 0, 0, 4'b0000, 5'b00010, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b11, 0);
`ifdef PCU_EXTENDED_OPS_EN
      // addi / bne / j supported
      step(0, 8,   1, 0, 0, 0,  0, 4'b0100, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b01, 0);
      step(0, 9,   1, 0, 0, 1,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 63,  1, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 1);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 5,   1, 1, 2, 0,  0, 4'b0001, 5'b00000, 2'b00, 0);
      step(0, 2,   1, 0, 0, 0,  0, 4'b0000, 5'b01000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00100, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
`else
      // addi / bne / j unsupported: bubble plus one-cycle illegalOp
      step(0, 8,   1, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 1);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 9,   1, 0, 0, 1,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 63,  1, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 1);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 5,   1, 1, 2, 0,  0, 4'b0000, 5'b00000, 2'b00, 1);
      step(0, 2,   1, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 1);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
`endif
      // reset with all three stages full
      step(0, R,   1, 1, 2, 0,  0, 4'b1010, 5'b00000, 2'b00, 0);
      step(0, LW,  1, 3, 4, 0,  0, 4'b0100, 5'b00000, 2'b00, 0);
      step(0, R,   1, 7, 8, 0,  0, 4'b1010, 5'b00010, 2'b01, 0);
      step(1, SW,  1, 1, 2, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      // reset while stalled
      step(0, LW,  1, 1, 3, 0,  0, 4'b0100, 5'b00000, 2'b00, 0);
      step(1, R,   1, 3, 0, 0,  1, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, R,   1, 3, 0, 0,  0, 4'b1010, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b00, 0);
      step(0, 0,   0, 0, 0, 0,  0, 4'b0000, 5'b00000, 2'b01, 0);

      for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
